// File: rtl/lu_operand_feeder_if.sv
// Operand-pair handshake bundle between an upstream producer, the feeder and the logic-unit stage.
interface lu_operand_feeder_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             sweep_start;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             sweep_done;
  logic [LW-1:0]    level;

  modport master (
    output in_valid, in_a, in_b, sweep_start, out_ready,
    input  in_ready, out_valid, a, b, busy, sweep_done, level
  );

  modport slave (
    input  in_valid, in_a, in_b, sweep_start, out_ready,
    output in_ready, out_valid, a, b, busy, sweep_done, level
  );
endinterface

// File: rtl/lu_operand_feeder.sv
// Operand feeder for the logic unit: a small pair FIFO, or an exhaustive a/b sweep on request.
module lu_operand_feeder #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  lu_operand_feeder_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t             state, state_nxt;
  logic [AW-1:0]      wptr, rptr;
  logic [AW:0]        level_q;
  logic [2*WIDTH-1:0] cnt;
  logic               done_q;
  logic [WIDTH-1:0]   mem_a [DEPTH];
  logic [WIDTH-1:0]   mem_b [DEPTH];

  logic               in_rdy, out_vld, push, pop, fifo_pop, last_pop;
  logic [WIDTH-1:0]   a_o, b_o;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_rdy    = 1'b0;
    out_vld   = 1'b0;
    a_o       = '0;
    b_o       = '0;
    push      = 1'b0;
    pop       = 1'b0;
    last_pop  = 1'b0;
    case (state)
      IDLE: begin
        in_rdy  = (level_q < FULL);
        out_vld = (level_q != '0);
        // a/b stay at zero while nothing valid is held
        if (out_vld) begin
          a_o = mem_a[rptr];
          b_o = mem_b[rptr];
        end
        push = bus.in_valid & in_rdy;
        pop  = out_vld & bus.out_ready;
        if (bus.sweep_start && level_q == '0 && !push) state_nxt = SWEEP;
      end
      SWEEP: begin
        out_vld = 1'b1;
        a_o     = cnt[2*WIDTH-1:WIDTH];
        b_o     = cnt[WIDTH-1:0];
        pop     = bus.out_ready;
        if (pop && (&cnt)) begin
          last_pop  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign fifo_pop = pop & (state == IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      level_q <= '0;
      cnt     <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= last_pop;
      if (push)     wptr <= wptr + 1'b1;
      if (fifo_pop) rptr <= rptr + 1'b1;
      case ({push, fifo_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      // counter is held at zero in IDLE so every sweep starts from pair 0
      if (state == IDLE) cnt <= '0;
      else if (pop)      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wptr] <= bus.in_a;
      mem_b[wptr] <= bus.in_b;
    end
  end

  assign bus.in_ready   = in_rdy;
  assign bus.out_valid  = out_vld;
  assign bus.a          = a_o;
  assign bus.b          = b_o;
  assign bus.busy       = (state == SWEEP);
  assign bus.sweep_done = done_q;
  assign bus.level      = level_q;
endmodule
